// File: rtl/vga_scanout.sv
// vga_scanout: monochrome framebuffer scan-out engine on the pixel clock.
// Generates VGA timing, fetches 32-bit words through a one-outstanding
// read port into a small FIFO, and serialises them one bit per pixel
// (LSB = leftmost pixel) into 2-bit RGB with hsync/vsync/blank.
//
// Ports:
//   clk_pixel      pixel clock, the only clock
//   reset          asynchronous, active-high
//   mem_req        read request, held until mem_ack
//   mem_addr       word address, stable while mem_req=1
//   mem_ack        read data valid, completes the request
//   mem_rdata      read data, valid with mem_ack
//   underflow_clr  clears the sticky underflow flag
//   underflow      sticky: a pixel word was needed while the FIFO was empty
//   vga_hsync      horizontal sync (active level HSYNC_POL)
//   vga_vsync      vertical sync (active level VSYNC_POL)
//   vga_blank      1 outside the visible area
//   vga_r/g/b      2-bit colour channels, 11 for a set pixel, 00 otherwise

module vga_scanout #(
    parameter int                H_VISIBLE  = 1024,
    parameter int                H_FP       = 24,
    parameter int                H_SYNC     = 136,
    parameter int                H_BP       = 160,
    parameter int                V_VISIBLE  = 768,
    parameter int                V_FP       = 3,
    parameter int                V_SYNC     = 6,
    parameter int                V_BP       = 29,
    parameter logic              HSYNC_POL  = 1'b0,
    parameter logic              VSYNC_POL  = 1'b0,
    parameter int                ADDR_W     = 18,
    parameter logic [ADDR_W-1:0] FB_BASE    = '0,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clk_pixel,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              underflow_clr,
    output logic              underflow,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank,
    output logic [1:0]        vga_r,
    output logic [1:0]        vga_g,
    output logic [1:0]        vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WORDS   = V_VISIBLE * H_VISIBLE / 32;
    localparam int CW      = $clog2(WORDS + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int NW      = AW + 1;

    localparam logic [HW-1:0] HC_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HC_VIS   = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VC_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VC_VIS   = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CW-1:0] WORDS_C  = CW'(WORDS);
    localparam logic [NW-1:0] DEPTH_C  = NW'(FIFO_DEPTH);

    typedef enum logic {
        F_IDLE,
        F_WAIT
    } fetch_t;

    // timing counters
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;

    // FIFO
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;

    // fetch engine
    fetch_t        state;
    fetch_t        state_nx;
    logic          req_start;
    logic [ADDR_W-1:0] ptr;
    logic [CW-1:0] fetched;
    logic          stale;

    // pixel path
    logic [31:0]   shreg;
    logic [31:0]   word;
    logic          pix;

    logic h_vis;
    logic v_vis;
    logic vis;
    logic hs_act;
    logic vs_act;
    logic flush;
    logic pop_slot;
    logic fifo_empty;
    logic push;
    logic pop;
    logic want;

    // ------------------------------------------------------------------
    // Timing decode
    // ------------------------------------------------------------------
    always_comb begin
        h_vis    = (hc < HC_VIS);
        v_vis    = (vc < VC_VIS);
        vis      = h_vis && v_vis;
        hs_act   = (hc >= HS_START) && (hc < HS_END);
        vs_act   = (vc >= VS_START) && (vc < VS_END);
        flush    = (hc == '0) && (vc == VC_VIS);
        pop_slot = vis && (hc[4:0] == 5'd0);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HC_LAST) begin
            hc <= '0;
            vc <= (vc == VC_LAST) ? '0 : vc + VW'(1);
        end else begin
            hc <= hc + HW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign pop        = pop_slot && !fifo_empty;

    // A stale (pre-flush) ack and an ack landing on the flush clock are
    // both dropped so the new frame starts from an empty FIFO.
    assign push = (state == F_WAIT) && mem_ack && !stale && !flush;

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch engine
    // ------------------------------------------------------------------
    assign mem_req = (state == F_WAIT);

    // No new request on the flush clock: the pointer is being rewound.
    assign want = (fetched < WORDS_C)
               && ((count + NW'(mem_req)) < DEPTH_C)
               && !flush;

    always_comb begin
        state_nx  = state;
        req_start = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (want) begin
                    state_nx  = F_WAIT;
                    req_start = 1'b1;
                end
            end
            F_WAIT: begin
                if (mem_ack) begin
                    state_nx = F_IDLE;
                end
            end
            default: state_nx = F_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= F_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            ptr      <= FB_BASE;
            fetched  <= '0;
            stale    <= 1'b0;
            mem_addr <= FB_BASE;
        end else begin
            if (req_start) begin
                mem_addr <= ptr;
            end
            if (flush) begin
                ptr     <= FB_BASE;
                fetched <= '0;
                // request still waiting for its ack belongs to the old frame
                stale   <= (state == F_WAIT) && !mem_ack;
            end else if ((state == F_WAIT) && mem_ack) begin
                if (stale) begin
                    stale <= 1'b0;
                end else begin
                    ptr     <= ptr + ADDR_W'(1);
                    fetched <= fetched + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel path and registered outputs
    // ------------------------------------------------------------------
    // On a word boundary the pixel comes straight from the FIFO head (or
    // zeros on underflow) so it lines up with sync/blank.
    always_comb begin
        word = shreg;
        if (pop_slot) begin
            word = fifo_empty ? '0 : fifo_mem[rd_ptr];
        end
        pix = word[hc[4:0]];
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (pop_slot) begin
            shreg <= word;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (pop_slot && fifo_empty) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
            vga_blank <= 1'b1;
            vga_r     <= 2'b00;
            vga_g     <= 2'b00;
            vga_b     <= 2'b00;
        end else begin
            vga_hsync <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            vga_blank <= ~vis;
            vga_r     <= (vis && pix) ? 2'b11 : 2'b00;
            vga_g     <= (vis && pix) ? 2'b11 : 2'b00;
            vga_b     <= (vis && pix) ? 2'b11 : 2'b00;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout on a tiny 40x5 raster.
// Reference timing/pixel model, memory responder and request monitor.

module tb_vga_scanout;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        underflow_clr;
    logic        underflow;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank;
    logic [1:0]  vga_r;
    logic [1:0]  vga_g;
    logic [1:0]  vga_b;

    vga_scanout #(
        .H_VISIBLE (32),
        .H_FP      (2),
        .H_SYNC    (4),
        .H_BP      (2),
        .V_VISIBLE (2),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0),
        .ADDR_W    (18),
        .FB_BASE   (18'h100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .underflow_clr(underflow_clr),
        .underflow    (underflow),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .vga_blank    (vga_blank),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [8:0] vec;
    assign vec = {vga_hsync, vga_vsync, vga_blank, vga_r, vga_g, vga_b};

    int n_vec = 0;
    int n_bad = 0;

    logic [8:0]  exp_q[$];
    logic [17:0] exp_addr[$];
    int          ack_hold = 0;
    int          mhc = 0;
    int          mvc = 0;
    int          hs_lo;
    int          vs_lo;
    int          bl_lo;
    logic        mon_p = 1'b0;
    logic [17:0] mon_a = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        if (a == 18'h100) return 32'h0000_0001;
        if (a == 18'h101) return 32'hFFFF_FFFF;
        return 32'hDEAD_BEEF;
    endfunction

    // mode 0: steady frame; 1: first frame after reset with prompt acks
    // (line0 underflows, line1 shows word 0x100); 2: fully dark frame
    function automatic logic [8:0] model(input int mode);
        logic [31:0] w;
        logic        vis;
        logic        p;
        logic [1:0]  c;
        logic        hs;
        logic        vs;
        logic [4:0]  bit_i;
        vis = (mhc < 32) && (mvc < 2);
        case (mode)
            0:       w = (mvc == 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            1:       w = (mvc == 0) ? 32'h0 : 32'h0000_0001;
            default: w = 32'h0;
        endcase
        bit_i = mhc[4:0];
        p  = vis && w[bit_i];
        c  = p ? 2'b11 : 2'b00;
        hs = !((mhc >= 34) && (mhc < 38));
        vs = (mvc != 3);
        return {hs, vs, !vis, c, c, c};
    endfunction

    task automatic run(input int n, input int mode);
        logic [8:0] e;
        hs_lo = 0;
        vs_lo = 0;
        bl_lo = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(mode));
            if (mhc == 0 && mvc == 2) begin
                exp_addr = {18'h100, 18'h101};
            end
            @(posedge clk_pixel);
            #1;
            e = exp_q.pop_front();
            check("pix", vec, e);
            if (!vga_hsync) hs_lo++;
            if (!vga_vsync) vs_lo++;
            if (!vga_blank) bl_lo++;
            mhc++;
            if (mhc == 40) begin
                mhc = 0;
                mvc = (mvc == 4) ? 0 : mvc + 1;
            end
        end
    endtask

    task automatic frame_checks();
        check("hs_lo", hs_lo, 20);
        check("vs_lo", vs_lo, 40);
        check("bl_lo", bl_lo, 64);
        check("addr_done", exp_addr.size(), 0);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        underflow_clr = 1'b0;
        ack_hold = hold;
        repeat (2) @(posedge clk_pixel);
        #1;
        exp_q.delete();
        check("rst_out", vec, 9'h1C0);
        check("rst_req", mem_req, 1'b0);
        check("rst_uf", underflow, 1'b0);
        @(negedge clk_pixel);
        mhc = 0;
        mvc = 0;
        exp_addr = {18'h100, 18'h101};
        reset = 1'b0;
    endtask

    // memory responder: ack one clock after the request is seen
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (reset) begin
                mem_ack = 1'b0;
            end else begin
                if (ack_hold > 0) ack_hold--;
                if (mem_ack) begin
                    mem_ack = 1'b0;
                end else if (mem_req && ack_hold == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                end
            end
        end
    end

    // request monitor: address trace and address stability
    initial begin
        forever begin
            @(negedge clk_pixel);
            if (mem_req && mon_p) begin
                check("addr_stable", mem_addr, mon_a);
            end
            if (mem_req && !mon_p) begin
                int avail;
                avail = exp_addr.size();
                check("req_avail", avail > 0, 1'b1);
                if (avail > 0) begin
                    check("req_addr", mem_addr, exp_addr.pop_front());
                end
            end
            mon_p = mem_req;
            mon_a = mem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        underflow_clr = 1'b0;

        // prompt acks: first frame misaligned, then steady frames
        do_reset(0);
        run(200, 1);
        check("uf_set", underflow, 1'b1);
        underflow_clr = 1'b1;
        run(200, 0);
        frame_checks();
        underflow_clr = 1'b0;
        check("uf_clr", underflow, 1'b0);
        run(200, 0);
        frame_checks();
        check("uf_stay0", underflow, 1'b0);

        // async reset mid-line with a request outstanding
        do_reset(1000);
        run(10, 2);
        check("pre_req", mem_req, 1'b1);
        check("pre_uf", underflow, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_out", vec, 9'h1C0);
        check("arst_req", mem_req, 1'b0);
        check("arst_uf", underflow, 1'b0);

        // acks held 100 clks: underflow frame, stale ack, recovery
        do_reset(100);
        run(200, 2);
        check("uf_hold", underflow, 1'b1);
        check("addr_done0", exp_addr.size(), 0);
        run(200, 0);
        frame_checks();
        check("uf_sticky", underflow, 1'b1);

        // ack arriving 3 clks after flush is dropped
        do_reset(83);
        run(200, 2);
        run(200, 0);
        frame_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
